sha3_scan_job_sequencer: RTL and testbench

// Host-side initiator for the SHA3 scanner control block. Accepts one scan job
// (threshold + block template) over a valid/ready handshake and registers it.

---
 rtl/sha3_scanner_pkg.sv | 23 ++
 rtl/sha3_scan_job_sequencer.sv | 130 +++++++++++++
 tb/tb_sha3_scan_job_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_scanner_pkg.sv
// Shared types for the SHA3 scan job sequencer: FSM states, template geometry
// helpers and the result record.
package sha3_scanner_pkg;

   typedef enum logic [2:0] {SYNC, IDLE, LOAD, ARM, RUN, REPORT} seq_state_e;

   function automatic int tpl_words(input int proper);
      return (proper != 0) ? 20 : 24;
   endfunction

   function automatic int scan_start_index(input int proper);
      return (proper != 0) ? 19 : 21;
   endfunction

   typedef struct packed {
      logic              found;
      logic              error;
      logic [31:0]       nonce;
      logic [31:0]       tested;
      logic [24:0][63:0] hash;
   } scan_result_t;

endpackage

// File: rtl/sha3_scan_job_sequencer.sv
// Host-side job sequencer for the SHA3 scanner: takes one job, pulses start,
// follows the scanner status lines and hands back one result record.
module sha3_scan_job_sequencer
   import sha3_scanner_pkg::*;
#(
   parameter  int PROPER    = 1,
   parameter  int WATCHDOG  = 1024,
   localparam int TPL_WORDS = tpl_words(PROPER)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [63:0]                   job_threshold,
   input  logic [TPL_WORDS-1:0][31:0]    job_template,
   output logic                          start,
   output logic [63:0]                   threshold,
   output logic [TPL_WORDS-1:0][31:0]    blockTemplate,
   input  logic                          ocapture,
   input  logic [24:0][63:0]             ohash,
   input  logic [31:0]                   ononce,
   input  logic                          odispatching,
   input  logic                          oawaiting,
   input  logic                          oevaluating,
   input  logic [31:0]                   scan_count,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic                          res_found,
   output logic                          res_error,
   output logic [31:0]                   res_nonce,
   output logic [24:0][63:0]             res_hash,
   output logic [31:0]                   res_tested,
   output logic                          busy
);

   localparam int          SS_IDX  = scan_start_index(PROPER);
   localparam logic [31:0] WD_LAST = 32'(WATCHDOG - 1);

   seq_state_e   state;
   scan_result_t res;
   logic [31:0]  wd_cnt;

   // Status/limit inputs the sequencer does not act on.
   logic unused_inputs;
   assign unused_inputs = ^{odispatching, scan_count};

   assign res_found  = res.found;
   assign res_error  = res.error;
   assign res_nonce  = res.nonce;
   assign res_tested = res.tested;
   assign res_hash   = res.hash;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SYNC;
         job_ready     <= 1'b0;
         start         <= 1'b0;
         busy          <= 1'b0;
         res_valid     <= 1'b0;
         threshold     <= '0;
         blockTemplate <= '0;
         res           <= '0;
         wd_cnt        <= '0;
      end else begin
         start <= 1'b0;
         case (state)
            // Scanner has no reset: let any in-flight scan drain first.
            SYNC: begin
               if (!oawaiting) begin
                  state     <= IDLE;
                  job_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  busy <= 1'b1;
               end
            end
            IDLE: begin
               if (job_valid && job_ready) begin
                  threshold     <= job_threshold;
                  blockTemplate <= job_template;
                  job_ready     <= 1'b0;
                  start         <= 1'b1;
                  busy          <= 1'b1;
                  state         <= LOAD;
               end
            end
            LOAD: begin
               res    <= '0;
               wd_cnt <= '0;
               state  <= ARM;
            end
            ARM: begin
               if (oawaiting) begin
                  state <= RUN;
               end else if (wd_cnt == WD_LAST) begin
                  res.error <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= REPORT;
               end else begin
                  wd_cnt <= wd_cnt + 32'd1;
               end
            end
            RUN: begin
               if (oevaluating && (res.tested != '1))
                  res.tested <= res.tested + 32'd1;
               // Only the first capture counts; flush-time captures are dropped.
               if (ocapture && !res.found) begin
                  res.found <= 1'b1;
                  res.hash  <= ohash;
                  res.nonce <= blockTemplate[SS_IDX] + ononce;
               end
               if (!oawaiting) begin
                  res_valid <= 1'b1;
                  state     <= REPORT;
               end
            end
            REPORT: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  job_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_scan_job_sequencer.sv
// Directed bench for sha3_scan_job_sequencer with a cycle-level scanner model.
module tb_sha3_scan_job_sequencer;

   localparam int TPL = 20;
   typedef logic [24:0][63:0]     hash_t;
   typedef logic [TPL-1:0][31:0]  tpl_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid, job_ready;
   logic [63:0] job_threshold;
   tpl_t        job_template;
   logic        start;
   logic [63:0] threshold;
   tpl_t        blockTemplate;
   logic        ocapture;
   hash_t       ohash;
   logic [31:0] ononce;
   logic        odispatching, oawaiting, oevaluating;
   logic [31:0] scan_count;
   logic        res_valid, res_ready, res_found, res_error;
   logic [31:0] res_nonce, res_tested;
   hash_t       res_hash;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sha3_scan_job_sequencer #(.PROPER(1), .WATCHDOG(16)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_threshold(job_threshold), .job_template(job_template),
      .start(start), .threshold(threshold), .blockTemplate(blockTemplate),
      .ocapture(ocapture), .ohash(ohash), .ononce(ononce),
      .odispatching(odispatching), .oawaiting(oawaiting), .oevaluating(oevaluating),
      .scan_count(scan_count),
      .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
      .res_error(res_error), .res_nonce(res_nonce), .res_hash(res_hash),
      .res_tested(res_tested), .busy(busy)
   );

   function automatic hash_t hash_of(input int k);
      hash_t h;
      for (int w = 0; w < 25; w++)
         h[w] = {32'hA5A50000 ^ 32'(k), 32'(w) * 32'h01010101};
      return h;
   endfunction

   // Offer a job at post-edge time; returns one edge later with the DUT in LOAD.
   task automatic offer_job(input logic [63:0] thr, input logic [31:0] base);
      tpl_t t;
      for (int i = 0; i < TPL; i++) t[i] = 32'(i) * 32'h01000001;
      t[19] = base;
      job_threshold = thr;
      job_template  = t;
      job_valid     = 1'b1;
      @(posedge clk); #1;
      job_valid     = 1'b0;
      job_template  = '0;
      job_threshold = '0;
   endtask

   // Scanner model: oawaiting one cycle after start, n evaluations (capture on
   // evaluation cap_a/cap_b with ononce = index), then oawaiting falls with an
   // optional capture in the same cycle. Returns one edge after the fall.
   task automatic scan(input int n, input int cap_a, input int cap_b,
                       input bit cap_fall, input int fall_off);
      @(posedge clk); #1;
      oawaiting = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         oevaluating = 1'b1;
         ocapture    = (i == cap_a) || (i == cap_b);
         ononce      = 32'(i);
         ohash       = hash_of(i);
      end
      @(posedge clk); #1;
      oevaluating = 1'b0;
      oawaiting   = 1'b0;
      ocapture    = cap_fall;
      ononce      = 32'(fall_off);
      ohash       = hash_of(fall_off);
      @(posedge clk); #1;
      ocapture    = 1'b0;
      ohash       = '0;
      ononce      = '0;
   endtask

   task automatic ack;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      oawaiting = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL rst_job_ready got %b want 0", job_ready); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", start); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
      checks++; if (threshold !== 64'h0) begin errors++; $display("FAIL rst_threshold got %h want 0", threshold); end
      checks++; if (blockTemplate !== '0) begin errors++; $display("FAIL rst_template got %h want 0", blockTemplate); end
      rst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL sync_job_ready got %b want 0", job_ready); end
      end
      oawaiting = 1'b0;
      @(posedge clk); #1;
      checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL sync_release got %b want 1", job_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_capture;
      offer_job(64'h0123_4567_89AB_CDEF, 32'h100);
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b want 1", start); end
      checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL busy_job_ready got %b want 0", job_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL job_busy got %b want 1", busy); end
      checks++; if (threshold !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL reg_threshold got %h want 0123456789abcdef", threshold); end
      checks++; if (blockTemplate[19] !== 32'h100) begin errors++; $display("FAIL reg_tpl19 got %h want 100", blockTemplate[19]); end
      checks++; if (blockTemplate[3] !== 32'h03000003) begin errors++; $display("FAIL reg_tpl3 got %h want 03000003", blockTemplate[3]); end
      scan(8, 5, -1, 1'b0, 0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL cap_valid got %b want 1", res_valid); end
      checks++; if (res_found !== 1'b1) begin errors++; $display("FAIL cap_found got %b want 1", res_found); end
      checks++; if (res_error !== 1'b0) begin errors++; $display("FAIL cap_error got %b want 0", res_error); end
      checks++; if (res_nonce !== 32'h105) begin errors++; $display("FAIL cap_nonce got %h want 105", res_nonce); end
      checks++; if (res_hash !== hash_of(5)) begin errors++; $display("FAIL cap_hash got %h want %h", res_hash, hash_of(5)); end
      checks++; if (res_tested !== 32'd8) begin errors++; $display("FAIL cap_tested got %0d want 8", res_tested); end
      checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL report_job_ready got %b want 0", job_ready); end
      ack();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ack_valid got %b want 0", res_valid); end
      checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL ack_job_ready got %b want 1", job_ready); end
   endtask

   task automatic test_double_capture;
      offer_job(64'h1, 32'h100);
      scan(10, 5, 7, 1'b0, 0);
      checks++; if (res_nonce !== 32'h105) begin errors++; $display("FAIL dbl_nonce got %h want 105", res_nonce); end
      checks++; if (res_hash !== hash_of(5)) begin errors++; $display("FAIL dbl_hash got %h want %h", res_hash, hash_of(5)); end
      checks++; if (res_tested !== 32'd10) begin errors++; $display("FAIL dbl_tested got %0d want 10", res_tested); end
      ack();
   endtask

   task automatic test_wrap;
      offer_job(64'h2, 32'hFFFF_FFFE);
      scan(6, 3, -1, 1'b0, 0);
      checks++; if (res_nonce !== 32'h1) begin errors++; $display("FAIL wrap_nonce got %h want 1", res_nonce); end
      checks++; if (res_found !== 1'b1) begin errors++; $display("FAIL wrap_found got %b want 1", res_found); end
      ack();
   endtask

   task automatic test_capture_on_fall;
      offer_job(64'h3, 32'h2000);
      scan(4, -1, -1, 1'b1, 9);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL fall_valid got %b want 1", res_valid); end
      checks++; if (res_found !== 1'b1) begin errors++; $display("FAIL fall_found got %b want 1", res_found); end
      checks++; if (res_nonce !== 32'h2009) begin errors++; $display("FAIL fall_nonce got %h want 2009", res_nonce); end
      checks++; if (res_hash !== hash_of(9)) begin errors++; $display("FAIL fall_hash got %h want %h", res_hash, hash_of(9)); end
      checks++; if (res_tested !== 32'd4) begin errors++; $display("FAIL fall_tested got %0d want 4", res_tested); end
      ack();
   endtask

   task automatic test_exhaust;
      offer_job(64'h4, 32'h500);
      scan(300, -1, -1, 1'b0, 0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL exh_valid got %b want 1", res_valid); end
      checks++; if (res_found !== 1'b0) begin errors++; $display("FAIL exh_found got %b want 0", res_found); end
      checks++; if (res_tested !== 32'd300) begin errors++; $display("FAIL exh_tested got %0d want 300", res_tested); end
      checks++; if (res_hash !== '0) begin errors++; $display("FAIL exh_hash got %h want 0", res_hash); end
      ack();
   endtask

   task automatic test_watchdog;
      offer_job(64'h5, 32'h700);
      repeat (16) @(posedge clk);
      #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", res_valid); end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL wd_valid got %b want 1", res_valid); end
      checks++; if (res_error !== 1'b1) begin errors++; $display("FAIL wd_error got %b want 1", res_error); end
      checks++; if (res_found !== 1'b0) begin errors++; $display("FAIL wd_found got %b want 0", res_found); end
      checks++; if (res_tested !== 32'd0) begin errors++; $display("FAIL wd_tested got %0d want 0", res_tested); end
      checks++; if (res_nonce !== 32'd0) begin errors++; $display("FAIL wd_nonce got %h want 0", res_nonce); end
      checks++; if (res_hash !== '0) begin errors++; $display("FAIL wd_hash got %h want 0", res_hash); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (res_valid !== 1'b1 || res_error !== 1'b1 || job_ready !== 1'b0 || res_tested !== 32'd0) begin
            errors++;
            $display("FAIL wd_hold cycle %0d got valid=%b err=%b rdy=%b tested=%0d want 1 1 0 0",
                     c, res_valid, res_error, job_ready, res_tested);
         end
      end
      ack();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL wd_ack_valid got %b want 0", res_valid); end
      checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL wd_ack_ready got %b want 1", job_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_ack_busy got %b want 0", busy); end
   endtask

   initial begin
      rst = 1'b1;
      job_valid = 1'b0; job_threshold = '0; job_template = '0;
      ocapture = 1'b0; ohash = '0; ononce = '0;
      odispatching = 1'b0; oawaiting = 1'b0; oevaluating = 1'b0;
      scan_count = 32'h2000_0000;
      res_ready = 1'b0;
      test_reset();
      test_capture();
      test_double_capture();
      test_wrap();
      test_capture_on_fall();
      test_exhaust();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
